entropy_harvest: RTL and testbench
==================================

# entropy_harvest

Consumer-side companion to `entropy_pool`. It samples the pool's serial `e_bit` stream, optionally debiases it with a von Neumann extractor, and runs a repetition-count health test on the raw bits. Good bits are packed into WIDTH-bit words, which are buffered in a small FIFO and handed to a core or the management bus over a valid/ready read port. It sits between `entropy_pool` and any random-number consumer.

## Interface
- `WIDTH`, 16: output word width; matches the pool's word width.
- `DEPTH`, 4: FIFO depth in words; must be a power of two and at least 2.
- `DEBIAS`, 1: 1 enables the von Neumann extractor; 0 passes raw bits straight through.
- `REP_LIMIT`, 32: length of an identical-raw-bit run that trips the fault; range 2..255.
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `e_bit`  in  1  raw entropy bit from `entropy_pool`.
- `en`  in  1  sample enable; `e_bit` is consumed only on edges where `en`=1.
- `clr`  in  1  synchronous flush: clears fault, run counter, extractor, accumulator, FIFO and `drop_cnt`.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `rd_valid`  out  1  FIFO non-empty.
- `rd_data`  out  WIDTH  FIFO head word.
- `fill`  out  $clog2(DEPTH+1)  number of words in the FIFO.
- `fault`  out  1  sticky health-test failure.
- `drop_cnt`  out  8  saturating count of words lost to a full FIFO.

## Operation
- **Reset.** Asserting `rst` immediately zeroes all state and outputs, with no clock edge needed: `rd_valid`=0, `rd_data`=0, `fill`=0, `fault`=0, `drop_cnt`=0, run counter 0, extractor phase 0, accumulator count 0.
- **Sample.** A sample happens on each rising edge where `en`=1, `clr`=0 and `fault`=0.
- **Health test.** The run counter `run` tracks consecutive identical raw bits.
  - On a sample: if `run`=0 or `e_bit`≠`last`, then `run`=1; otherwise `run`=`run`+1. `last` is updated to `e_bit` every sample.
  - When `run` reaches REP_LIMIT on an edge, `fault` sets on that same edge and that edge's bit is not emitted.
  - `fault` stays set until `rst` or `clr`. While `fault`=1 there are no samples and no pushes. Reads continue normally.
- **Extractor, DEBIAS=1.** Two states.
  - PH0: store `e_bit` as `a`, go to PH1.
  - PH1: if `e_bit`≠`a`, emit `a`. Go to PH0 either way.
  - Pairs 00 and 11 emit nothing.
- **Extractor, DEBIAS=0.** Every sample emits `e_bit`.
- **Packing.** Each emitted bit shifts in at the LSB: `acc <= {acc[WIDTH-2:0], bit}`, `cnt++`.
  - The first emitted bit of a word ends up in the MSB.
  - When a bit is emitted with `cnt`=WIDTH-1, the completed word `{acc[WIDTH-2:0], bit}` is pushed on that edge and `cnt` returns to 0.
- **FIFO.** Circular buffer with a read pointer, a write pointer and `fill`; pointers wrap modulo DEPTH.
  - A pop occurs on an edge where `rd_valid`=1 and `rd_ready`=1.
  - A push with `fill`=DEPTH and no pop on the same edge drops the word and increments `drop_cnt`, which saturates at 255.
  - Push and pop on the same edge while full: both succeed, no drop, `fill` unchanged.
  - Push and pop on the same edge while `fill`=1: both succeed, `rd_valid` stays 1.
- **Clear.** `clr` takes priority over sample, push and pop on the same edge.

## Timing
- `rd_valid`, `fill`, `fault` and `drop_cnt` are registered.
- `rd_data` is a combinational read of the FIFO memory at the read pointer. It is 0 when empty.
- Latency with DEBIAS=0 and `en` held high: the first word is visible (`rd_valid`=1) right after the WIDTH-th sampling edge.
- Latency with DEBIAS=1: at least 2·WIDTH sampling edges per word.
- The consumer may hold `rd_ready` high continuously, giving one pop per cycle while `rd_valid`=1.
- `rd_data` changes only after a pop, or after a push into an empty FIFO.

## Test plan
- **Raw packing.** DEBIAS=0, WIDTH=16. Drive `en`=1 and `e_bit` = 0111110000111001 over 16 edges → `rd_valid`=1, `rd_data`=16'h7C39, `fill`=1.
- **Debiasing.** DEBIAS=1. Drive 32 raw bits as the pairs "10","01" repeated, with a "00" and an "11" pair inserted → `rd_data`=16'hAAAA after 36 edges, `fault`=0.
- **Overflow.** DEPTH=4, DEBIAS=0, `rd_ready`=0, 80 sampling edges of alternating bits → `fill`=4, `drop_cnt`=1, `rd_data`=16'hAAAA. Then with `rd_ready`=1 held during the next push edge → no further drop.
- **Health fault.** DEBIAS=0, REP_LIMIT=32, constant `e_bit`=1 → 16'hFFFF pushed at edge 16 and `fault`=1 at edge 32. Then `clr` for one cycle → `fault`=0, `fill`=0, `drop_cnt`=0, and sampling resumes.
- **Reset mid-operation.** With `fill`=2 and a partial word in the accumulator, pulse `rst` between clock edges → all outputs read 0 before the next edge. After release, the first word needs a full 16 fresh edges.
- **Back-to-back reads.** Fill 3 words, then hold `rd_ready`=1 → exactly 3 pops on consecutive cycles in push order, then `rd_valid`=0.

Source files
------------

// File: rtl/entropy_harvest.sv
// Entropy harvester: samples a serial raw-bit stream, runs a repetition-count
// health test, optionally von Neumann debiases, packs bits MSB-first into
// WIDTH-bit words and buffers them in a DEPTH-word FIFO behind a valid/ready read port.
// Ports: clk/rst (async active-high); e_bit/en raw sample input; clr sync flush;
//        rd_ready/rd_valid/rd_data read port; fill, fault, drop_cnt status.
module entropy_harvest #(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int DEBIAS    = 1,
  parameter int REP_LIMIT = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       e_bit,
  input  logic                       en,
  input  logic                       clr,
  input  logic                       rd_ready,
  output logic                       rd_valid,
  output logic [WIDTH-1:0]           rd_data,
  output logic [$clog2(DEPTH+1)-1:0] fill,
  output logic                       fault,
  output logic [7:0]                 drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(WIDTH);
  localparam int FW = $clog2(DEPTH+1);

  logic [7:0]       run;
  logic             last;
  logic             phase;
  logic             a;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             sample;
  logic [7:0]       run_nxt;
  logic             trip;
  logic             emit;
  logic             ebit;
  logic [WIDTH-1:0] word;
  logic             push;
  logic             pop;
  logic             full;
  logic             wr;
  logic             drop;
  logic [FW-1:0]    fill_nxt;

  always_comb begin
    sample  = en & ~clr & ~fault;
    run_nxt = (run == 8'd0 || e_bit != last) ? 8'd1 : run + 8'd1;
    // The bit that completes a forbidden run is swallowed, not emitted.
    trip    = sample && (run_nxt == 8'(REP_LIMIT));
    emit    = 1'b0;
    ebit    = e_bit;
    if (DEBIAS != 0) begin
      emit = sample & ~trip & phase & (e_bit != a);
      ebit = a;
    end else begin
      emit = sample & ~trip;
    end
    word = {acc[WIDTH-2:0], ebit};
    push = emit && (cnt == CW'(WIDTH-1));
    pop  = rd_valid & rd_ready & ~clr;
    full = (fill == FW'(DEPTH));
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    wr   = push & (~full | pop);
    drop = push & full & ~pop;
    fill_nxt = fill;
    if (wr && !pop)      fill_nxt = fill + FW'(1);
    else if (!wr && pop) fill_nxt = fill - FW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run      <= '0;
      last     <= 1'b0;
      phase    <= 1'b0;
      a        <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      wp       <= '0;
      rp       <= '0;
      fill     <= '0;
      rd_valid <= 1'b0;
      fault    <= 1'b0;
      drop_cnt <= '0;
    end else if (clr) begin
      run      <= '0;
      last     <= 1'b0;
      phase    <= 1'b0;
      a        <= 1'b0;
      acc      <= '0;
      cnt      <= '0;
      wp       <= '0;
      rp       <= '0;
      fill     <= '0;
      rd_valid <= 1'b0;
      fault    <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (sample) begin
        last <= e_bit;
        run  <= run_nxt;
        if (trip) fault <= 1'b1;
        else begin
          phase <= ~phase;
          if (!phase) a <= e_bit;
        end
      end
      if (emit) begin
        acc <= word;
        cnt <= push ? '0 : cnt + CW'(1);
      end
      if (wr)  wp <= wp + PW'(1);
      if (pop) rp <= rp + PW'(1);
      fill     <= fill_nxt;
      rd_valid <= (fill_nxt != '0);
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  // Storage needs no reset: rd_data is forced to 0 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (wr && !rst) mem[wp] <= word;
  end

  assign rd_data = rd_valid ? mem[rp] : '0;

endmodule

// File: tb/tb_entropy_harvest.sv
module tb_entropy_harvest;

  logic        clk = 1'b0;
  logic        rst, e_bit, en, clr, rd_ready;
  logic        raw_valid, vn_valid;
  logic [15:0] raw_data, vn_data;
  logic [2:0]  raw_fill, vn_fill;
  logic        raw_fault, vn_fault;
  logic [7:0]  raw_drop, vn_drop;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  entropy_harvest #(.WIDTH(16), .DEPTH(4), .DEBIAS(0), .REP_LIMIT(32)) u_raw (
    .clk(clk), .rst(rst), .e_bit(e_bit), .en(en), .clr(clr), .rd_ready(rd_ready),
    .rd_valid(raw_valid), .rd_data(raw_data), .fill(raw_fill),
    .fault(raw_fault), .drop_cnt(raw_drop));

  entropy_harvest #(.WIDTH(16), .DEPTH(4), .DEBIAS(1), .REP_LIMIT(32)) u_vn (
    .clk(clk), .rst(rst), .e_bit(e_bit), .en(en), .clr(clr), .rd_ready(rd_ready),
    .rd_valid(vn_valid), .rd_data(vn_data), .fill(vn_fill),
    .fault(vn_fault), .drop_cnt(vn_drop));

  typedef struct {
    logic [15:0] pattern;
    logic [15:0] exp_data;
    logic [2:0]  exp_fill;
  } vec_t;

  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    e_bit = b;
    en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [15:0] w);
    logic [15:0] t;
    t = w;
    for (int k = 15; k >= 0; k--) send_bit(t[k]);
  endtask

  task automatic do_clear();
    en  = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
  endtask

  initial begin
    rst = 1'b1; e_bit = 1'b0; en = 1'b0; clr = 1'b0; rd_ready = 1'b0;
    tbl[0] = '{16'b0111110000111001, 16'h7C39, 3'd1};
    tbl[1] = '{16'b1010101010101010, 16'hAAAA, 3'd1};
    tbl[2] = '{16'b0000000011111111, 16'h00FF, 3'd1};
    tbl[3] = '{16'b1100101011110000, 16'hCAF0, 3'd1};
    tbl[4] = '{16'b0001001000110100, 16'h1234, 3'd1};

    #2;
    check("reset rd_valid", 32'(raw_valid), 32'd0);
    check("reset rd_data",  32'(raw_data),  32'd0);
    check("reset fill",     32'(raw_fill),  32'd0);
    check("reset fault",    32'(raw_fault), 32'd0);
    check("reset drop_cnt", 32'(raw_drop),  32'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Raw packing, table driven: MSB-first ordering and one-word latency.
    for (int i = 0; i < 5; i++) begin
      logic [15:0] p;
      do_clear();
      p = tbl[i].pattern;
      for (int k = 15; k >= 1; k--) send_bit(p[k]);
      check($sformatf("raw[%0d] valid before 16th", i), 32'(raw_valid), 32'd0);
      send_bit(p[0]);
      en = 1'b0;
      check($sformatf("raw[%0d] rd_valid", i), 32'(raw_valid), 32'd1);
      check($sformatf("raw[%0d] rd_data", i),  32'(raw_data),  32'(tbl[i].exp_data));
      check($sformatf("raw[%0d] fill", i),     32'(raw_fill),  32'(tbl[i].exp_fill));
    end

    // Debiasing: 10/01 pairs emit 1/0, with a 00 and an 11 pair that emit nothing.
    do_clear();
    begin
      int n;
      n = 0;
      for (int pr = 0; pr < 18; pr++) begin
        if (pr == 4)      begin send_bit(1'b0); send_bit(1'b0); end
        else if (pr == 9) begin send_bit(1'b1); send_bit(1'b1); end
        else begin
          if (n % 2 == 0) begin send_bit(1'b1); send_bit(1'b0); end
          else begin
            if (n == 15) begin
              send_bit(1'b0);
              check("vn fill before last edge", 32'(vn_fill), 32'd0);
              send_bit(1'b1);
            end else begin
              send_bit(1'b0); send_bit(1'b1);
            end
          end
          n++;
        end
      end
    end
    en = 1'b0;
    check("vn rd_valid", 32'(vn_valid), 32'd1);
    check("vn rd_data",  32'(vn_data),  32'hAAAA);
    check("vn fault",    32'(vn_fault), 32'd0);
    check("vn fill",     32'(vn_fill),  32'd1);

    // Overflow: 5 words into a 4-deep FIFO with no reads.
    do_clear();
    rd_ready = 1'b0;
    for (int k = 0; k < 80; k++) send_bit((k % 2) == 0);
    check("ovf fill",     32'(raw_fill), 32'd4);
    check("ovf drop_cnt", 32'(raw_drop), 32'd1);
    check("ovf rd_data",  32'(raw_data), 32'hAAAA);
    for (int k = 80; k < 95; k++) send_bit((k % 2) == 0);
    rd_ready = 1'b1;
    send_bit(1'b0);
    rd_ready = 1'b0;
    en = 1'b0;
    check("ovf push+pop fill", 32'(raw_fill), 32'd4);
    check("ovf push+pop drop", 32'(raw_drop), 32'd1);

    // Health fault with constant ones.
    do_clear();
    check("clr drop_cnt", 32'(raw_drop), 32'd0);
    check("clr fill",     32'(raw_fill), 32'd0);
    for (int k = 0; k < 16; k++) send_bit(1'b1);
    check("hlth word",    32'(raw_data), 32'hFFFF);
    check("hlth fill16",  32'(raw_fill), 32'd1);
    for (int k = 16; k < 31; k++) send_bit(1'b1);
    check("hlth fault@31", 32'(raw_fault), 32'd0);
    send_bit(1'b1);
    check("hlth fault@32", 32'(raw_fault), 32'd1);
    for (int k = 0; k < 20; k++) send_bit(1'b1);
    en = 1'b0;
    check("hlth blocked fill", 32'(raw_fill), 32'd1);
    check("hlth sticky",       32'(raw_fault), 32'd1);
    do_clear();
    check("hlth clr fault", 32'(raw_fault), 32'd0);
    check("hlth clr fill",  32'(raw_fill),  32'd0);
    check("hlth clr valid", 32'(raw_valid), 32'd0);
    send_word(16'h5A5A);
    en = 1'b0;
    check("hlth resume data", 32'(raw_data), 32'h5A5A);
    check("hlth resume fill", 32'(raw_fill), 32'd1);

    // Asynchronous reset mid-operation.
    do_clear();
    send_word(16'h1234);
    send_word(16'h5678);
    for (int k = 0; k < 5; k++) send_bit(k[0]);
    en = 1'b0;
    check("rst pre fill", 32'(raw_fill), 32'd2);
    rst = 1'b1;
    #1;
    check("async rst rd_valid", 32'(raw_valid), 32'd0);
    check("async rst rd_data",  32'(raw_data),  32'd0);
    check("async rst fill",     32'(raw_fill),  32'd0);
    check("async rst fault",    32'(raw_fault), 32'd0);
    check("async rst drop",     32'(raw_drop),  32'd0);
    #1 rst = 1'b0;
    begin
      logic [15:0] w;
      w = 16'hC3A5;
      for (int k = 15; k >= 1; k--) send_bit(w[k]);
      check("post rst partial", 32'(raw_valid), 32'd0);
      send_bit(w[0]);
      en = 1'b0;
      check("post rst data", 32'(raw_data), 32'hC3A5);
    end

    // Back-to-back reads.
    do_clear();
    send_word(16'h1234);
    send_word(16'hABCD);
    send_word(16'h0F0F);
    en = 1'b0;
    check("b2b fill3", 32'(raw_fill), 32'd3);
    rd_ready = 1'b1;
    check("b2b head0", 32'(raw_data), 32'h1234);
    @(posedge clk); #1;
    check("b2b head1", 32'(raw_data), 32'hABCD);
    check("b2b fill2", 32'(raw_fill), 32'd2);
    @(posedge clk); #1;
    check("b2b head2", 32'(raw_data), 32'h0F0F);
    check("b2b valid", 32'(raw_valid), 32'd1);
    @(posedge clk); #1;
    check("b2b empty valid", 32'(raw_valid), 32'd0);
    check("b2b empty data",  32'(raw_data),  32'd0);
    check("b2b empty fill",  32'(raw_fill),  32'd0);
    rd_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
